bcd_counter_mux: RTL and testbench
==================================

Name: bcd_counter_mux

Overview:
- Parametrised multi-digit successor to the single-digit seconds counter.
- A prescaler generates a count tick. The tick drives a DIGITS-wide BCD counter with up/down, hold, load and wrap flag.
- Digits are time-multiplexed onto one 7-segment output with a one-hot digit strobe and optional leading-zero blanking.
- Sits between the top-level switch inputs and the 7-segment and digit-select pins.

Parameters:
- DIGITS, 4, number of BCD digits (1..8).
- PRESCALE_W, 24, prescaler width in bits.
- MAX_COUNT, 10_000_000, default prescaler terminal value, used when rate_sel == 0.
- MUX_DIV_W, 10, refresh divider width; each digit is shown for 2^MUX_DIV_W cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = count on tick; 0 = hold value (prescaler keeps running).
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_value  in  4*DIGITS  BCD value to load; digit 0 = bits [3:0].
- rate_sel  in  8  0 = use MAX_COUNT; otherwise terminal = {rate_sel, 10'b0}, zero-extended to PRESCALE_W.
- blank_lz  in  1  1 = blank leading zeros.
- count_bcd  out  4*DIGITS  current BCD count, registered.
- tick  out  1  one-cycle pulse at prescaler terminal.
- wrap  out  1  one-cycle pulse when the count wraps.
- segments  out  7  segment pattern for the strobed digit, seg7 encoding, registered.
- digit_sel  out  DIGITS  one-hot digit strobe, registered.

Behaviour:
- Reset (sync, priority over everything):
  - prescaler = 0, count_bcd = 0, tick = 0, wrap = 0.
  - mux index = 0, refresh counter = 0.
  - digit_sel = 1 (digit 0), segments = seg7 pattern of 0.
- Prescaler:
  - Increments each cycle.
  - When prescaler >= terminal: prescaler <= 0 and tick = 1 on the next cycle.
  - Tick period = terminal + 1 cycles.
  - Using >= means lowering rate_sel below the current prescaler value terminates immediately, with no 2^PRESCALE_W rollover.
  - Terminal 0 gives a tick every cycle.
- Count update, evaluated on the cycle tick is high:
  - load = 1 (priority over tick): count_bcd <= load_value and prescaler <= 0. Any nibble > 9 loads as 0. No wrap pulse.
  - enable = 1, up_down = 1: BCD increment with ripple carry. Digit 9 -> 0 carries into the next digit. All-9 -> all-0 asserts wrap for one cycle, coincident with the new value.
  - enable = 1, up_down = 0: BCD decrement with ripple borrow. Digit 0 -> 9 borrows. All-0 -> all-9 asserts wrap.
  - enable = 0: count holds, no wrap.
  - load without tick still loads. Load is accepted on any cycle.
- Latency: count_bcd changes the cycle after tick. wrap is aligned with that change.
- Multiplexer:
  - A free-running MUX_DIV_W refresh counter drives digit advance. On its all-ones cycle, the mux index advances 0..DIGITS-1 and wraps to 0.
  - digit_sel = one-hot(index).
  - segments = seg7(count_bcd digit[index]), registered, valid the same cycle digit_sel updates. Both derive from the same next-index value, so there is no glitch.
  - Blanking: when blank_lz = 1, a digit is blanked (segments = 0) if it and every more-significant digit are 0. Digit 0 is never blanked.
  - Count changes mid-scan appear at the next segments register update.
- Reset mid-operation: all state returns to reset values on the next edge. Pending tick and wrap are dropped.
- Scaling: DIGITS = 1 degenerates to a single-digit 0..9 counter. digit_sel is then constant 1.

Test Plan:
- Reset, MAX_COUNT = 4, rate_sel = 0, enable = 1, up: tick every 5 cycles. count_bcd = 0x0001 after the first tick, 0x0002 after the second. tick is exactly one cycle wide.
- load_value = 0x9998, up, enable: after 2 ticks count = 0x0000 with wrap = 1 for exactly one cycle. Load 0x0000, down, one tick: 0x9999 with wrap = 1.
- load_value = 0x12A4: count_bcd = 0x1204 (invalid nibble loaded as 0) and the prescaler restarts at 0. load asserted together with tick: the load wins and no increment occurs.
- enable = 0 for 10 ticks: count holds and wrap stays 0. Change rate_sel from 0 to 1 while prescaler = 5000 (terminal 1024): tick on the next cycle and prescaler = 0.
- MUX_DIV_W = 2, count 0x0305: digit_sel cycles 0001 -> 0010 -> 0100 -> 1000 every 4 cycles with segments = seg7(5), seg7(0), seg7(3), seg7(0). With blank_lz = 1, digit 3 shows 0 and digit 1 still shows seg7(0).
- Assert reset mid-count with count 0x0042 and prescaler nonzero: next cycle count = 0, prescaler = 0, digit_sel = 0001, segments = seg7(0), tick = wrap = 0.

Source files
------------

// File: rtl/bcd_counter_mux_if.sv
// bcd_counter_mux_if: control inputs and display/count outputs of the BCD
// counter. The master drives enable/up_down/load/load_value/rate_sel/blank_lz
// and observes count_bcd/tick/wrap/segments/digit_sel; the slave (the counter)
// does the reverse.
interface bcd_counter_mux_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  up_down;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [7:0]            rate_sel;
    logic                  blank_lz;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  tick;
    logic                  wrap;
    logic [6:0]            segments;
    logic [DIGITS-1:0]     digit_sel;

    modport master (
        output enable, up_down, load, load_value, rate_sel, blank_lz,
        input  count_bcd, tick, wrap, segments, digit_sel
    );

    modport slave (
        input  enable, up_down, load, load_value, rate_sel, blank_lz,
        output count_bcd, tick, wrap, segments, digit_sel
    );
endinterface

// File: rtl/bcd_counter_mux.sv
// bcd_counter_mux: prescaled multi-digit BCD up/down counter with load, hold
// and wrap flag, time-multiplexed onto one 7-segment output.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - bcd_counter_mux_if.slave: enable, up_down, load, load_value,
//           rate_sel, blank_lz in; count_bcd, tick, wrap, segments,
//           digit_sel out (all outputs registered)
// Segment encoding is active-high {g,f,e,d,c,b,a}.
module bcd_counter_mux #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 24,
    parameter int MAX_COUNT  = 10_000_000,
    parameter int MUX_DIV_W  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    bcd_counter_mux_if.slave       bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW    = 4 * DIGITS;

    logic [PRESCALE_W-1:0] presc_q, presc_d, term;
    logic                  tick_q, tick_d, wrap_q, wrap_d;
    logic [CW-1:0]         count_q, count_d, load_clean, step_val;
    logic                  carry;
    logic [MUX_DIV_W-1:0]  ref_q, ref_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGITS-1:0]     sel_q, sel_d, zero_from;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            digit;
    logic                  zacc;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Terminal compare uses >= so a lowered rate terminates at once instead
    // of running the prescaler all the way round.
    always_comb begin
        term = (bus.rate_sel == 8'd0) ? PRESCALE_W'(MAX_COUNT)
                                      : PRESCALE_W'({bus.rate_sel, 10'b0});
        tick_d  = 1'b0;
        presc_d = presc_q + 1'b1;
        if (bus.load) begin
            presc_d = '0;   // load restarts the tick period
        end else if (presc_q >= term) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
    end

    // Invalid (>9) nibbles on load are forced to zero.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clean[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9)
                                 ? 4'd0 : bus.load_value[4*i +: 4];
        end
    end

    // Ripple carry/borrow; carry left set after the top digit means wrap.
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bus.up_down) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = load_clean;
        end else if (tick_q && bus.enable) begin
            count_d = step_val;
            wrap_d  = carry;
        end
    end

    // Display: segments and strobe both come from idx_d so they change together.
    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == '1) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        zacc      = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zacc         = zacc & (count_q[4*i +: 4] == 4'd0);
            zero_from[i] = zacc;
        end
        digit = 4'd0;
        sel_d = '0;
        seg_d = 7'h00;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                digit    = count_q[4*i +: 4];
                sel_d[i] = 1'b1;
                seg_d    = (bus.blank_lz && i != 0 && zero_from[i]) ? 7'h00
                                                                     : seg7(digit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            sel_q   <= DIGITS'(1);
            seg_q   <= 7'h3F;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
    assign bus.segments  = seg_q;
    assign bus.digit_sel = sel_q;
endmodule

// File: tb/tb_bcd_counter_mux.sv
// Randomized bench for bcd_counter_mux with a cycle-level reference model that
// holds the count as a plain integer and derives BCD, wrap and display from it.
module tb_bcd_counter_mux;
    localparam int D  = 4;
    localparam int PW = 24;
    localparam int MC = 4;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    bcd_counter_mux_if #(.DIGITS(D)) bus ();

    bcd_counter_mux #(
        .DIGITS(D), .PRESCALE_W(PW), .MAX_COUNT(MC), .MUX_DIV_W(MW)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // model state
    int         m_presc = 0, m_count = 0, m_ref = 0, m_idx = 0;
    bit         m_tick = 0, m_wrap = 0;
    logic [6:0] m_seg = 7'h3F;
    logic [D-1:0] m_sel = 1;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int clean_val(input logic [4*D-1:0] lv);
        int s = 0;
        for (int i = 0; i < D; i++)
            if (lv[4*i +: 4] <= 4'd9) s += int'(lv[4*i +: 4]) * pow10(i);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one clock edge of the reference model, using the inputs held across it
    task automatic step();
        int n_presc, n_count, n_ref, n_idx, term, dig, top;
        bit n_tick, n_wrap, blank;
        if (rst) begin
            m_presc = 0; m_count = 0; m_tick = 0; m_wrap = 0;
            m_ref = 0; m_idx = 0; m_sel = 1; m_seg = 7'h3F;
            return;
        end
        top  = pow10(D) - 1;
        term = (bus.rate_sel == 0) ? MC : int'(bus.rate_sel) * 1024;
        n_tick = 0; n_wrap = 0; n_count = m_count;
        if (bus.load) n_presc = 0;
        else if (m_presc >= term) begin n_presc = 0; n_tick = 1; end
        else n_presc = m_presc + 1;
        if (bus.load) n_count = clean_val(bus.load_value);
        else if (m_tick && bus.enable) begin
            if (bus.up_down) begin
                if (m_count == top) begin n_count = 0; n_wrap = 1; end
                else n_count = m_count + 1;
            end else begin
                if (m_count == 0) begin n_count = top; n_wrap = 1; end
                else n_count = m_count - 1;
            end
        end
        n_ref = (m_ref + 1) % (1 << MW);
        n_idx = (m_ref == (1 << MW) - 1) ? (m_idx + 1) % D : m_idx;
        dig   = (m_count / pow10(n_idx)) % 10;
        blank = bus.blank_lz && n_idx != 0 && m_count < pow10(n_idx);
        m_seg = blank ? 7'h00 : SEG[dig];
        m_sel = D'(1 << n_idx);
        m_presc = n_presc; m_tick = n_tick; m_wrap = n_wrap;
        m_count = n_count; m_ref = n_ref; m_idx = n_idx;
    endtask

    task automatic cycle();
        @(posedge clk);
        step();
        #1;
        chk("count", 32'(bus.count_bcd), 32'(to_bcd(m_count)));
        chk("tick", 32'(bus.tick), 32'(m_tick));
        chk("wrap", 32'(bus.wrap), 32'(m_wrap));
        chk("digit_sel", 32'(bus.digit_sel), 32'(m_sel));
        chk("segments", 32'(bus.segments), 32'(m_seg));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [4*D-1:0] v);
        bus.load = 1'b1; bus.load_value = v;
        cycle();
        bus.load = 1'b0;
    endtask

    initial begin
        int r;
        bus.enable = 1'b0; bus.up_down = 1'b1; bus.load = 1'b0;
        bus.load_value = '0; bus.rate_sel = 8'd0; bus.blank_lz = 1'b0;
        rst = 1'b1;
        run(2);
        chk("rst_count", 32'(bus.count_bcd), 32'h0);
        chk("rst_sel", 32'(bus.digit_sel), 32'h1);
        chk("rst_seg", 32'(bus.segments), 32'h3F);
        rst = 1'b0;

        // count up at tick period 5
        bus.enable = 1'b1; bus.up_down = 1'b1;
        run(12);
        chk("up_two_ticks", 32'(bus.count_bcd), 32'h0002);

        // wrap up from 9998, then wrap down from 0000
        do_load(16'h9998);
        run(12);
        do_load(16'h0000);
        bus.up_down = 1'b0;
        run(6);

        // invalid nibble loads as zero
        do_load(16'h12A4);
        chk("load_clean", 32'(bus.count_bcd), 32'h1204);

        // hold
        bus.enable = 1'b0;
        run(60);
        chk("hold", 32'(bus.count_bcd), 32'h1204);

        // lowering the terminal below the running prescaler fires at once
        bus.rate_sel = 8'd8; bus.enable = 1'b1; bus.up_down = 1'b1;
        do_load(16'h0305);
        run(5000);
        bus.rate_sel = 8'd1;
        cycle();
        chk("rate_drop_tick", 32'(bus.tick), 32'h1);
        bus.enable = 1'b0; bus.rate_sel = 8'd0;

        // display scan with and without blanking
        run(20);
        bus.blank_lz = 1'b1;
        run(20);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.load = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 3);
            case (r)
                0: bus.load_value = 16'h9998;
                1: bus.load_value = 16'h0001;
                2: bus.load_value = 16'($urandom);
                default: bus.load_value = 16'h0000;
            endcase
            bus.enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) bus.up_down = ~bus.up_down;
            if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
            cycle();
        end
        rst = 1'b0; bus.load = 1'b0;

        // reset in the middle of counting
        bus.enable = 1'b1; bus.up_down = 1'b1;
        do_load(16'h0042);
        run(3);
        rst = 1'b1;
        cycle();
        chk("midrst_count", 32'(bus.count_bcd), 32'h0);
        chk("midrst_sel", 32'(bus.digit_sel), 32'h1);
        chk("midrst_seg", 32'(bus.segments), 32'h3F);
        chk("midrst_tick", 32'(bus.tick), 32'h0);
        chk("midrst_wrap", 32'(bus.wrap), 32'h0);
        rst = 1'b0;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
